// File: rtl/l2_req_arbiter.sv
// Icache/Dcache arbiter in front of a single-outstanding L2 port: IDLE captures a winner, REQ
// presents it to L2, WAIT holds until L2 returns data. Define L2_ARB_STARVE_EN for Icache anti-starvation.
module l2_req_arbiter #(
  parameter int unsigned LINE_W     = 128,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              icache_req,
  input  logic [31:0]       icache_addr,
  output logic              arb_icache_addrOK,
  output logic              arb_icache_dataOK,
  output logic [LINE_W-1:0] arb_icache_dout,
  input  logic              dcache_req,
  input  logic              dcache_wr,
  input  logic [31:0]       dcache_addr,
  input  logic [31:0]       dcache_din,
  input  logic [3:0]        dcache_wstrb,
  output logic              arb_dcache_addrOK,
  output logic              arb_dcache_dataOK,
  output logic [LINE_W-1:0] arb_dcache_dout,
  output logic              arb_l2_req,
  output logic              arb_l2_wr,
  output logic [31:0]       arb_l2_addr,
  output logic [31:0]       arb_l2_din,
  output logic [3:0]        arb_l2_wstrb,
  input  logic              l2_arb_addrOK,
  input  logic              l2_arb_dataOK,
  input  logic [LINE_W-1:0] l2_arb_dout
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("STARVE_MAX must lie in 1..15");
  end

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] din_q;
  logic        wr_q;
  logic [3:0]  wstrb_q;
  logic        owner_dc_q;

  logic idle;
  logic force_ic;
  logic grant_dc;
  logic grant_ic;
  logic l2_done;

`ifdef L2_ARB_STARVE_EN
  logic [3:0] starve_q;

  assign force_ic = (starve_q == 4'(STARVE_MAX)) && icache_req && dcache_req;

  // Counts Dcache grants taken while the Icache was also waiting.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_q <= 4'd0;
    end else if (grant_dc && icache_req) begin
      if (starve_q != 4'(STARVE_MAX)) starve_q <= starve_q + 4'd1;
    end else if (grant_dc || grant_ic) begin
      starve_q <= 4'd0;
    end
  end
`else
  assign force_ic = 1'b0;
`endif

  // addrOK is combinational in the capture cycle, so it must be masked while reset is held.
  assign idle     = rstn && (state_q == StIdle);
  assign grant_dc = idle && dcache_req && !force_ic;
  assign grant_ic = idle && icache_req && !grant_dc;
  assign l2_done  = l2_arb_dataOK &&
                    ((state_q == StWait) || ((state_q == StReq) && l2_arb_addrOK));

  assign arb_dcache_addrOK = grant_dc;
  assign arb_icache_addrOK = grant_ic;
  assign arb_dcache_dataOK = l2_done && owner_dc_q;
  assign arb_icache_dataOK = l2_done && !owner_dc_q;
  assign arb_dcache_dout   = l2_arb_dout;
  assign arb_icache_dout   = l2_arb_dout;

  assign arb_l2_req   = (state_q == StReq);
  assign arb_l2_wr    = wr_q;
  assign arb_l2_addr  = addr_q;
  assign arb_l2_din   = din_q;
  assign arb_l2_wstrb = wstrb_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      addr_q     <= 32'd0;
      din_q      <= 32'd0;
      wr_q       <= 1'b0;
      wstrb_q    <= 4'd0;
      owner_dc_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_dc || grant_ic) begin
            state_q    <= StReq;
            addr_q     <= grant_dc ? dcache_addr : icache_addr;
            din_q      <= grant_dc ? dcache_din : 32'd0;
            wr_q       <= grant_dc && dcache_wr;
            wstrb_q    <= grant_dc ? dcache_wstrb : 4'd0;
            owner_dc_q <= grant_dc;
          end
        end
        StReq: begin
          if (l2_arb_addrOK) state_q <= l2_arb_dataOK ? StIdle : StWait;
        end
        StWait: begin
          if (l2_arb_dataOK) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Bench for l2_req_arbiter: directed scenarios plus randomized transactions against a
// transaction-level model of the grant rules (honours L2_ARB_STARVE_EN if defined).
module tb_l2_req_arbiter;
  localparam int LW   = 128;
  localparam int SMAX = 4;
`ifdef L2_ARB_STARVE_EN
  localparam bit StarveEn = 1'b1;
`else
  localparam bit StarveEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          icache_req, dcache_req, dcache_wr;
  logic [31:0]   icache_addr, dcache_addr, dcache_din;
  logic [3:0]    dcache_wstrb;
  logic          arb_icache_addrOK, arb_icache_dataOK, arb_dcache_addrOK, arb_dcache_dataOK;
  logic [LW-1:0] arb_icache_dout, arb_dcache_dout, l2_arb_dout;
  logic          arb_l2_req, arb_l2_wr, l2_arb_addrOK, l2_arb_dataOK;
  logic [31:0]   arb_l2_addr, arb_l2_din;
  logic [3:0]    arb_l2_wstrb;

  int total = 0;
  int bad   = 0;
  int run_len = 0;  // consecutive Dcache grants made while the Icache was also requesting

  always #5 clk = ~clk;

  l2_req_arbiter #(.LINE_W(LW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rstn(rstn),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .arb_icache_addrOK(arb_icache_addrOK), .arb_icache_dataOK(arb_icache_dataOK),
    .arb_icache_dout(arb_icache_dout),
    .dcache_req(dcache_req), .dcache_wr(dcache_wr), .dcache_addr(dcache_addr),
    .dcache_din(dcache_din), .dcache_wstrb(dcache_wstrb),
    .arb_dcache_addrOK(arb_dcache_addrOK), .arb_dcache_dataOK(arb_dcache_dataOK),
    .arb_dcache_dout(arb_dcache_dout),
    .arb_l2_req(arb_l2_req), .arb_l2_wr(arb_l2_wr), .arb_l2_addr(arb_l2_addr),
    .arb_l2_din(arb_l2_din), .arb_l2_wstrb(arb_l2_wstrb),
    .l2_arb_addrOK(l2_arb_addrOK), .l2_arb_dataOK(l2_arb_dataOK), .l2_arb_dout(l2_arb_dout)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One full arbitration round starting in an IDLE cycle with requests already driven.
  // L2 accepts after a_dly stall cycles and returns data d_dly cycles after accepting.
  task automatic txn(input int a_dly, input int d_dly, input logic [127:0] line,
                     output bit got_d, output bit got_i);
    bit exp_d, exp_i, dok;
    logic [31:0] e_addr, e_din;
    logic e_wr;
    logic [3:0] e_wstrb;
    exp_d = dcache_req && !(StarveEn && run_len == SMAX && icache_req);
    exp_i = icache_req && !exp_d;
    got_d = exp_d;
    got_i = exp_i;
    l2_arb_dataOK = 1'($urandom_range(0, 1));
    #2;
    check("dcache_addrOK", arb_dcache_addrOK, exp_d);
    check("icache_addrOK", arb_icache_addrOK, exp_i);
    check("idle_dataOK", {arb_dcache_dataOK, arb_icache_dataOK}, 2'b00);
    check("idle_l2_req", arb_l2_req, 1'b0);
    if (!(exp_d || exp_i)) begin
      next_cycle();
      l2_arb_dataOK = 1'b0;
      return;
    end
    if (exp_d && icache_req) begin
      if (run_len < SMAX) run_len++;
    end else begin
      run_len = 0;
    end
    e_addr  = exp_d ? dcache_addr : icache_addr;
    e_wr    = exp_d ? dcache_wr : 1'b0;
    e_din   = dcache_din;
    e_wstrb = exp_d ? dcache_wstrb : 4'h0;
    next_cycle();
    for (int k = 0; k <= a_dly; k++) begin
      dok           = (k == a_dly) && (d_dly == 0);
      l2_arb_addrOK = (k == a_dly);
      l2_arb_dataOK = dok ? 1'b1 : 1'($urandom_range(0, 1));
      if (k != a_dly) l2_arb_dataOK = 1'($urandom_range(0, 1));
      else            l2_arb_dataOK = dok;
      l2_arb_dout   = dok ? line : rand_line();
      #2;
      check("req_l2_req", arb_l2_req, 1'b1);
      check("req_l2_addr", arb_l2_addr, e_addr);
      check("req_l2_wr", arb_l2_wr, e_wr);
      check("req_l2_wstrb", arb_l2_wstrb, e_wstrb);
      if (exp_d) check("req_l2_din", arb_l2_din, e_din);
      check("req_dcache_dataOK", arb_dcache_dataOK, dok && exp_d);
      check("req_icache_dataOK", arb_icache_dataOK, dok && exp_i);
      if (dok) check("req_dout", exp_d ? arb_dcache_dout : arb_icache_dout, line);
      next_cycle();
    end
    l2_arb_addrOK = 1'b0;
    for (int k = 1; k <= d_dly; k++) begin
      dok           = (k == d_dly);
      l2_arb_dataOK = dok;
      l2_arb_dout   = dok ? line : rand_line();
      #2;
      check("wait_l2_req", arb_l2_req, 1'b0);
      check("wait_dcache_dataOK", arb_dcache_dataOK, dok && exp_d);
      check("wait_icache_dataOK", arb_icache_dataOK, dok && exp_i);
      if (dok) begin
        check("wait_dcache_dout", arb_dcache_dout, line);
        check("wait_icache_dout", arb_icache_dout, line);
      end
      next_cycle();
    end
    l2_arb_dataOK = 1'b0;
  endtask

  initial begin
    bit gd, gi;
    logic [9:0] pattern;
    logic [127:0] aabb;
    aabb = {4{32'hAABBCCDD}};

    // Reset with both requesters and a stray L2 response active
    rstn = 1'b0; icache_req = 1'b1; dcache_req = 1'b1; dcache_wr = 1'b1;
    icache_addr = 32'h1; dcache_addr = 32'h2; dcache_din = 32'h3; dcache_wstrb = 4'hF;
    l2_arb_addrOK = 1'b1; l2_arb_dataOK = 1'b1; l2_arb_dout = '0;
    #2;
    check("rst_addrOK", {arb_dcache_addrOK, arb_icache_addrOK}, 2'b00);
    check("rst_dataOK", {arb_dcache_dataOK, arb_icache_dataOK}, 2'b00);
    check("rst_l2_req", arb_l2_req, 1'b0);
    check("rst_l2_fields", {arb_l2_wr, arb_l2_addr, arb_l2_din, arb_l2_wstrb}, 69'd0);
    next_cycle();
    next_cycle();
    icache_req = 1'b0; dcache_req = 1'b0; l2_arb_addrOK = 1'b0; l2_arb_dataOK = 1'b0;
    rstn = 1'b1;
    next_cycle();

    // Icache read: addrOK at N, l2_req at N+1, data at N+3, grantable again at N+4
    icache_req = 1'b1; icache_addr = 32'h1C00_0040;
    txn(0, 2, aabb, gd, gi);
    check("ic_only_winner", gi, 1'b1);
    icache_addr = 32'h1C00_0080;
    txn(0, 0, rand_line(), gd, gi);
    icache_req = 1'b0;

    // Contention: Dcache write first, then the Icache
    icache_req = 1'b1; dcache_req = 1'b1; dcache_wr = 1'b1;
    dcache_addr = 32'h0000_1000; dcache_din = 32'h1234_5678; dcache_wstrb = 4'hF;
    txn(1, 1, rand_line(), gd, gi);
    check("contend_first_d", gd, 1'b1);
    dcache_req = 1'b0;
    txn(0, 1, rand_line(), gd, gi);
    check("contend_then_i", gi, 1'b1);

    // Same-cycle addrOK+dataOK back to back
    icache_req = 1'b0; dcache_req = 1'b1; dcache_wr = 1'b0;
    txn(0, 0, rand_line(), gd, gi);
    txn(0, 0, rand_line(), gd, gi);
    check("b2b_grant", gd, 1'b1);

    // Both held continuously for ten rounds
    pattern = StarveEn ? 10'b1000010000 : 10'b0000000000;  // bit i set = Icache wins round i
    icache_req = 1'b1; dcache_req = 1'b0;
    txn(0, 0, rand_line(), gd, gi);
    dcache_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      txn($urandom_range(0, 2), $urandom_range(0, 2), rand_line(), gd, gi);
      check("starve_order", gi, pattern[i]);
    end

    // Randomized rounds
    for (int i = 0; i < 40; i++) begin
      icache_req = 1'($urandom_range(0, 1)); dcache_req = 1'($urandom_range(0, 1));
      icache_addr = $urandom(); dcache_addr = $urandom(); dcache_din = $urandom();
      dcache_wr = 1'($urandom_range(0, 1)); dcache_wstrb = 4'($urandom_range(0, 15));
      txn($urandom_range(0, 3), $urandom_range(0, 3), rand_line(), gd, gi);
    end

    // Reset while waiting for L2 data
    icache_req = 1'b0; dcache_req = 1'b1;
    #2;
    check("mid_rst_grant", arb_dcache_addrOK, 1'b1);
    next_cycle();
    l2_arb_addrOK = 1'b1;
    next_cycle();
    l2_arb_addrOK = 1'b0; dcache_req = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_l2_req", arb_l2_req, 1'b0);
    next_cycle();
    rstn = 1'b1; l2_arb_dataOK = 1'b1;
    #2;
    check("post_rst_dataOK", {arb_dcache_dataOK, arb_icache_dataOK}, 2'b00);
    check("post_rst_l2_req", arb_l2_req, 1'b0);
    next_cycle();
    l2_arb_dataOK = 1'b0; run_len = 0; dcache_req = 1'b1;
    txn(0, 1, rand_line(), gd, gi);
    check("post_rst_idle_grant", gd, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
